// File: rtl/myproject_mul_share_arb_if.sv
// ============================================================================
// Module : myproject_mul_share_arb_if
// Brief  : Requester / product-slot bundle for the shared multiplier arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface myproject_mul_share_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN_WIDTH  = 11,
    parameter int DOUT_WIDTH = 22
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*DIN_WIDTH-1:0] req_a;
    logic [NUM_REQ*DIN_WIDTH-1:0] req_b;
    logic                         res_valid;
    logic                         res_ready;
    logic [DOUT_WIDTH-1:0]        res_p;
    logic [ID_WIDTH-1:0]          res_id;
    logic [31:0]                  perf_busy_cnt;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, res_id, perf_busy_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, res_id, perf_busy_cnt
    );
endinterface

`default_nettype wire

// File: rtl/myproject_mul_share_arb.sv
// ============================================================================
// Module : myproject_mul_share_arb
// Brief  : Round-robin arbiter sharing one signed multiplier among NUM_REQ
//          requesters, with a single-entry registered product slot.
//          Define MYPROJECT_MUL_SHARE_PERF_EN to build the busy-cycle counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module myproject_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN_WIDTH  = 11,
    parameter int DOUT_WIDTH = 22
) (
    input  wire logic              ap_clk,
    input  wire logic              ap_rst,
    myproject_mul_share_arb_if.slave bus
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                       r_state;
    logic [ID_WIDTH-1:0]          r_ptr;
    logic [DOUT_WIDTH-1:0]        r_res_p;
    logic [ID_WIDTH-1:0]          r_res_id;

    logic                         w_can_accept;
    logic                         w_gnt_any;
    logic [ID_WIDTH-1:0]          w_gnt_idx;
    logic [ID_WIDTH-1:0]          w_ptr_next;
    logic [NUM_REQ-1:0]           w_ready;
    logic signed [DIN_WIDTH-1:0]  w_a;
    logic signed [DIN_WIDTH-1:0]  w_b;
    logic signed [DOUT_WIDTH-1:0] w_prod;

    assign w_can_accept = (r_state == S_EMPTY) || bus.res_ready;

    // First pass finds a requester at or above the pointer; the second pass
    // covers the wrap-around to the lowest indices.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_ready   = '0;
        w_a       = '0;
        w_b       = '0;
        if (w_can_accept) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_gnt_any && bus.req_valid[j] && (ID_WIDTH'(j) >= r_ptr)) begin
                    w_gnt_any  = 1'b1;
                    w_gnt_idx  = ID_WIDTH'(j);
                    w_ready[j] = 1'b1;
                    w_a        = bus.req_a[j*DIN_WIDTH +: DIN_WIDTH];
                    w_b        = bus.req_b[j*DIN_WIDTH +: DIN_WIDTH];
                end
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_gnt_any && bus.req_valid[j]) begin
                    w_gnt_any  = 1'b1;
                    w_gnt_idx  = ID_WIDTH'(j);
                    w_ready[j] = 1'b1;
                    w_a        = bus.req_a[j*DIN_WIDTH +: DIN_WIDTH];
                    w_b        = bus.req_b[j*DIN_WIDTH +: DIN_WIDTH];
                end
            end
        end
    end

    // Operands are sign-extended to the full product width so nothing is lost.
    assign w_prod     = DOUT_WIDTH'(w_a) * DOUT_WIDTH'(w_b);
    assign w_ptr_next = (w_gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : w_gnt_idx + ID_WIDTH'(1);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= S_EMPTY;
            r_ptr    <= '0;
            r_res_p  <= '0;
            r_res_id <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_gnt_any) r_state <= S_FULL;
                S_FULL:  if (bus.res_ready && !w_gnt_any) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
            if (w_gnt_any) begin
                r_res_p  <= w_prod;
                r_res_id <= w_gnt_idx;
                r_ptr    <= w_ptr_next;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.res_valid = (r_state == S_FULL);
    assign bus.res_p     = r_res_p;
    assign bus.res_id    = r_res_id;

`ifdef MYPROJECT_MUL_SHARE_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_perf_cnt <= '0;
        end else if (w_gnt_any) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign bus.perf_busy_cnt = r_perf_cnt;
`else
    assign bus.perf_busy_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_myproject_mul_share_arb.sv
// ============================================================================
// Module : tb_myproject_mul_share_arb
// Brief  : Directed self-checking bench for the shared multiplier arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_myproject_mul_share_arb;

    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int DIN_WIDTH  = 11;
    localparam int DOUT_WIDTH = 22;

`ifdef MYPROJECT_MUL_SHARE_PERF_EN
    localparam logic [31:0] c_perf_exp = 32'd10;
`else
    localparam logic [31:0] c_perf_exp = 32'd0;
`endif

    logic ap_clk;
    logic ap_rst;
    int   n_checks;
    int   n_err;

    myproject_mul_share_arb_if #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH),
        .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
    ) bus ();

    myproject_mul_share_arb #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH),
        .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .bus   (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [43:0] a;
        logic [43:0] b;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [21:0] exp_p;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [43:0] pk(input int x0, input int x1, input int x2, input int x3);
        return {11'(x3), 11'(x2), 11'(x1), 11'(x0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v, input logic [43:0] a, input logic [43:0] b);
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
    endtask

    task automatic chk_slot(input string nm, input logic rv, input logic [21:0] p, input logic [1:0] id);
        chk({nm, ".res_valid"}, 32'(bus.res_valid), 32'(rv));
        chk({nm, ".res_p"},     32'(bus.res_p),     32'(p));
        chk({nm, ".res_id"},    32'(bus.res_id),    32'(id));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;

        vecs[0] = '{4'b0010, pk(0, 3, 0, 0),     pk(0, -5, 0, 0),    4'b0010, 1'b1, 22'h3FFFF1, 2'd1};
        vecs[1] = '{4'b0001, pk(-1024, 0, 0, 0), pk(-1024, 0, 0, 0), 4'b0001, 1'b1, 22'h100000, 2'd0};
        vecs[2] = '{4'b0001, pk(-1024, 0, 0, 0), pk(1023, 0, 0, 0),  4'b0001, 1'b1, 22'h300400, 2'd0};
        vecs[3] = '{4'b0000, pk(0, 0, 0, 0),     pk(0, 0, 0, 0),     4'b0000, 1'b0, 22'h300400, 2'd0};
        vecs[4] = '{4'b1001, pk(2, 0, 0, 7),     pk(2, 0, 0, 8),     4'b1000, 1'b1, 22'h000038, 2'd3};
        vecs[5] = '{4'b1001, pk(2, 0, 0, 7),     pk(2, 0, 0, 8),     4'b0001, 1'b1, 22'h000004, 2'd0};
        vecs[6] = '{4'b0100, pk(0, 0, -3, 0),    pk(0, 0, -4, 0),    4'b0100, 1'b1, 22'h00000C, 2'd2};
        vecs[7] = '{4'b0000, pk(0, 0, 0, 0),     pk(0, 0, 0, 0),     4'b0000, 1'b0, 22'h00000C, 2'd2};

        // Reset state
        ap_rst = 1'b1;
        bus.res_ready = 1'b1;
        set_in(4'b0000, '0, '0);
        tick();
        tick();
        chk_slot("reset", 1'b0, 22'h0, 2'd0);
        chk("reset.perf", bus.perf_busy_cnt, 32'd0);
        ap_rst = 1'b0;

        // Table: single requester, extremes, wrap-around, idle drain
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].valid, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("vec%0d.req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            tick();
            chk_slot($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_p, vecs[i].exp_id);
        end

        // Round robin from a fresh pointer
        ap_rst = 1'b1;
        set_in(4'b0000, '0, '0);
        tick();
        ap_rst = 1'b0;
        set_in(4'b1111, pk(1, 2, 3, 4), pk(10, 10, 10, 10));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d.req_ready", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk_slot($sformatf("rr%0d", k), 1'b1, 22'((k % 4 + 1) * 10), 2'(k % 4));
        end

        // Perf: 6 transfers above, 4 more interleaved with 5 idle cycles
        for (int k = 0; k < 4; k++) begin
            set_in(4'b0000, '0, '0);
            tick();
            set_in(4'b0010, pk(0, 1, 0, 0), pk(0, 1, 0, 0));
            tick();
        end
        set_in(4'b0000, '0, '0);
        tick();
        chk("perf.busy_cnt", bus.perf_busy_cnt, c_perf_exp);

        // Backpressure: pointer is now 2
        bus.res_ready = 1'b0;
        set_in(4'b0100, pk(0, 0, 5, 0), pk(0, 0, 6, 0));
        #1;
        chk("bp.fill.req_ready", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        chk_slot("bp.fill", 1'b1, 22'd30, 2'd2);
        set_in(4'b0001, pk(9, 0, 0, 0), pk(9, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp.hold%0d.req_ready", k), 32'(bus.req_ready), 32'd0);
            tick();
            chk_slot($sformatf("bp.hold%0d", k), 1'b1, 22'd30, 2'd2);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp.release.req_ready", 32'(bus.req_ready), 32'(4'b0001));
        tick();
        chk_slot("bp.release", 1'b1, 22'd81, 2'd0);
        set_in(4'b0000, '0, '0);
        tick();
        chk("bp.drain.res_valid", 32'(bus.res_valid), 32'd0);

        // Reset while the slot is full and stalled
        bus.res_ready = 1'b0;
        set_in(4'b0010, pk(0, 2, 0, 0), pk(0, 2, 0, 0));
        tick();
        chk_slot("rstmid.fill", 1'b1, 22'd4, 2'd1);
        set_in(4'b0000, '0, '0);
        ap_rst = 1'b1;
        tick();
        chk_slot("rstmid.reset", 1'b0, 22'd0, 2'd0);
        ap_rst = 1'b0;
        bus.res_ready = 1'b1;
        set_in(4'b0100, pk(0, 0, 1, 0), pk(0, 0, 1, 0));
        #1;
        chk("rstmid.req2.req_ready", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        chk_slot("rstmid.req2", 1'b1, 22'd1, 2'd2);
        set_in(4'b1001, pk(5, 0, 0, 3), pk(5, 0, 0, 3));
        #1;
        chk("rstmid.ptr3.req_ready", 32'(bus.req_ready), 32'(4'b1000));
        tick();
        chk_slot("rstmid.ptr3", 1'b1, 22'd9, 2'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/myproject_mul_share_arb.md
Name: myproject_mul_share_arb

Overview:
- Round-robin arbiter that time-shares one signed DIN_WIDTH x DIN_WIDTH multiplier among NUM_REQ requesters.
- Each requester presents an operand pair on a valid/ready handshake. The block grants at most one pair per cycle and multiplies it on the shared combinational multiplier instance.
- The product, tagged with the requester index, is returned through a single-entry registered output slot with backpressure.
- Sits between the layer datapath engines and the shared DSP multiplier of the inference core.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_WIDTH, 2: width of the requester tag; must satisfy 2^ID_WIDTH >= NUM_REQ.
- DIN_WIDTH, 11: signed operand width.
- DOUT_WIDTH, 22: signed product width; must equal 2*DIN_WIDTH.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  in  NUM_REQ*DIN_WIDTH  packed operand A; requester i occupies bits [i*DIN_WIDTH +: DIN_WIDTH].
- req_b  in  NUM_REQ*DIN_WIDTH  packed operand B; same packing as req_a.
- res_valid  out  1  product slot full.
- res_ready  in  1  consumer accepts product.
- res_p  out  DOUT_WIDTH  signed product.
- res_id  out  ID_WIDTH  index of the requester that produced res_p.
- perf_busy_cnt  out  32  count of cycles with a grant (see Optional Feature).

Behaviour:
- Reset (ap_rst=1 on a clock edge):
  - res_valid=0, res_p=0, res_id=0.
  - RR pointer=0, so requester 0 has highest priority.
  - perf_busy_cnt=0.
  - Reset overrides all handshake activity; a product held in the slot is discarded.
- Slot state machine, two states:
  - EMPTY (res_valid=0): goes to FULL on a grant.
  - FULL (res_valid=1): on res_ready=1 with a grant in the same cycle, stays FULL and loads the new product. On res_ready=1 with no grant, goes to EMPTY. On res_ready=0, holds.
- can_accept = !res_valid | res_ready (combinational).
- Arbitration:
  - If can_accept, grant the first requester with req_valid=1, searching from index ptr upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only; all req_ready=0 when !can_accept or no requests.
  - req_ready is combinational from req_valid, res_valid, res_ready and ptr.
  - A transfer occurs when req_valid[g] & req_ready[g].
  - On a transfer, ptr <= (g+1) mod NUM_REQ. Otherwise ptr holds.
- Datapath:
  - On a transfer, res_p <= signed(req_a[g]) * signed(req_b[g]) at full DOUT_WIDTH (no truncation or saturation), and res_id <= g.
  - Latency: exactly 1 cycle from accept edge to res_valid=1.
  - Throughput: 1 product per cycle while res_ready=1.
- While res_valid=1 and res_ready=0, res_p and res_id are held stable.
- Requesters must hold req_valid and operands until granted. The block never depends on a valid being dropped.
- A request arriving in the same cycle as a slot drain (res_ready=1) is granted that cycle. There is no bubble.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Extreme value: -1024 * -1024 = +1048576 (0x100000), which is representable in 22 bits.

Optional Feature:
- Macro: MYPROJECT_MUL_SHARE_PERF_EN.
- When defined:
  - perf_busy_cnt increments by 1 on every cycle with a transfer.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by ap_rst.
- When undefined:
  - perf_busy_cnt is tied to constant 0 and no counter register is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset mid-operation: assert ap_rst while res_valid=1 and res_ready=0 -> next cycle res_valid=0, res_p=0, res_id=0; after release, a first request from req 2 only is granted and ptr becomes 3.
- Single requester: req 1 with a=3, b=-5, res_ready=1 -> req_ready=4'b0010 in the accept cycle; next cycle res_valid=1, res_p=-15 (22'h3FFFF1), res_id=1.
- Round robin: all 4 req_valid held high, res_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; one res_valid per cycle with res_id following the same order.
- Backpressure: slot full with res_ready=0 for 3 cycles and req 0 pending -> req_ready=0 and res_p/res_id stable for all 3 cycles; raising res_ready grants req 0 that cycle with no bubble.
- Width extremes: a=-1024, b=-1024 -> res_p=22'h100000; a=-1024, b=1023 -> res_p=-1047552 (22'h300400).
- Perf counter (macro defined): 10 transfers interleaved with 5 idle cycles -> perf_busy_cnt=10. With the macro undefined -> perf_busy_cnt stays 0.
